// File: rtl/layer7_ctrl_pkg.sv
// Shared types and constants for the layer-7 fully-connected sequencer.
package layer7_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int TAG_N_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               first;
    logic               last;
    logic [TAG_N_W-1:0] n;
  } pipe_tag_t;

endpackage

// File: rtl/layer7_ctrl_tagpipe.sv
// Two-deep shift register carrying the issue tag alongside the SRAM read latency.
module layer7_ctrl_tagpipe
  import layer7_ctrl_pkg::*;
#(
  parameter int W = $bits(pipe_tag_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tag_p0,
  output logic [W-1:0] tag_p1,
  output logic [W-1:0] tag_p2
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_p1 <= '0;
      tag_p2 <= '0;
    end else begin
      tag_p1 <= tag_p0;
      tag_p2 <= tag_p1;
    end
  end

endmodule

// File: rtl/layer7_controller.sv
// Sequencer for the layer-7 fully-connected datapath: issues input/weight/bias
// reads per neuron and chunk, drives accumulate control, writes biased results.
module layer7_controller
  import layer7_ctrl_pkg::*;
#(
  parameter int IN_CHUNKS   = 8,
  parameter int OUT_NEURONS = 10,
  parameter int IN_AW = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1,
  parameter int W_AW  = (IN_CHUNKS * OUT_NEURONS > 1) ? $clog2(IN_CHUNKS * OUT_NEURONS) : 1,
  parameter int O_AW  = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_rd_addr,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_rd_addr,
  output logic              bias_rd_en,
  output logic [O_AW-1:0]   bias_rd_addr,
  output logic              systolic_adder_control,
  input  logic [DATA_W-1:0] result_data,
  output logic              out_wr_en,
  output logic [O_AW-1:0]   out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data
);

  state_t           state_q, state_d;
  logic [IN_AW-1:0] k_q;
  logic [O_AW-1:0]  n_q;
  logic [W_AW-1:0]  w_q;
  logic             issue, k_last, n_last;
  pipe_tag_t        tag_p0, tag_p1, tag_p2;
  logic             wr_p2, done_p2;
  logic             unused_tag;

  assign k_last = (k_q == IN_AW'(IN_CHUNKS - 1));
  assign n_last = (n_q == O_AW'(OUT_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        issue = 1'b1;
        busy  = 1'b1;
        if (k_last && n_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue counters: chunk k, neuron n and the flat weight address advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      n_q <= '0;
      w_q <= '0;
    end else if (issue) begin
      if (k_last) begin
        k_q <= '0;
        n_q <= n_last ? '0 : n_q + 1'b1;
      end else begin
        k_q <= k_q + 1'b1;
      end
      w_q <= (k_last && n_last) ? '0 : w_q + 1'b1;
    end
  end

  assign in_rd_en   = issue;
  assign in_rd_addr = k_q;
  assign w_rd_en    = issue;
  assign w_rd_addr  = w_q;

  // Stage p0 -> p1 -> p2: tag follows the read data through the SRAM latency.
  assign tag_p0.valid = issue;
  assign tag_p0.first = (k_q == '0);
  assign tag_p0.last  = k_last;
  assign tag_p0.n     = TAG_N_W'(n_q);

  layer7_ctrl_tagpipe #(
    .W($bits(pipe_tag_t))
  ) u_tagpipe (
    .clk   (clk),
    .rst   (rst),
    .tag_p0(tag_p0),
    .tag_p1(tag_p1),
    .tag_p2(tag_p2)
  );

  // Stage p1: operands at the datapath; first chunk loads, the rest accumulate.
  assign systolic_adder_control = tag_p1.valid & ~tag_p1.first;
  assign bias_rd_en             = tag_p1.valid & tag_p1.last;
  assign bias_rd_addr           = O_AW'(tag_p1.n);

  // Stage p2: biased result is combinationally valid; capture it for the write.
  assign wr_p2   = tag_p2.valid & tag_p2.last;
  assign done_p2 = wr_p2 & (tag_p2.n == TAG_N_W'(OUT_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr_en   <= 1'b0;
      done        <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else begin
      out_wr_en <= wr_p2;
      done      <= done_p2;
      if (wr_p2) begin
        out_wr_addr <= O_AW'(tag_p2.n);
        out_wr_data <= result_data;
      end
    end
  end

  assign unused_tag = tag_p2.first;

endmodule
